// File: rtl/rv32_wb_pkg.sv
// Shared RV32 register-file writeback types and helpers.
package rv32_wb_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]   xlen_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    // x0 is hard-wired, so it never matches for hazard or forwarding purposes.
    function automatic logic idx_match(reg_idx_t a, reg_idx_t b);
        return (a != REG_ZERO) && (a == b);
    endfunction

endpackage

// File: rtl/rf_writeback_ctrl_if.sv
// Pipeline-side bus of the register-file writeback controller.
// Fields fwd1_en/fwd1_val/fwd2_en/fwd2_val exist only when RF_WB_FWD_EN is defined.
interface rf_writeback_ctrl_if
    import rv32_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) ();

    logic                     alu_valid;
    reg_idx_t                 alu_rd_in;
    xlen_t                    alu_result;

    logic                     ld_issue_valid;
    reg_idx_t                 ld_issue_rd;
    logic                     ld_issue_ready;
    logic                     ld_resp_valid;
    xlen_t                    ld_resp_data;
    logic                     ld_resp_ready;

    reg_idx_t                 chk_rs1;
    reg_idx_t                 chk_rs2;
    reg_idx_t                 chk_rd;
    logic                     hazard;

    logic                     wb_en;
    reg_idx_t                 wb_reg;
    xlen_t                    wb_val;
    logic                     alu_reg_w_en;
    reg_idx_t                 alu_rd;
    xlen_t                    alu_out;
    logic [$clog2(DEPTH):0]   outstanding;
`ifdef RF_WB_FWD_EN
    logic                     fwd1_en;
    xlen_t                    fwd1_val;
    logic                     fwd2_en;
    xlen_t                    fwd2_val;
`endif

    modport master (
        output alu_valid, alu_rd_in, alu_result,
        output ld_issue_valid, ld_issue_rd, ld_resp_valid, ld_resp_data,
        output chk_rs1, chk_rs2, chk_rd,
        input  ld_issue_ready, ld_resp_ready, hazard,
        input  wb_en, wb_reg, wb_val, alu_reg_w_en, alu_rd, alu_out, outstanding
`ifdef RF_WB_FWD_EN
        , input fwd1_en, fwd1_val, fwd2_en, fwd2_val
`endif
    );

    modport slave (
        input  alu_valid, alu_rd_in, alu_result,
        input  ld_issue_valid, ld_issue_rd, ld_resp_valid, ld_resp_data,
        input  chk_rs1, chk_rs2, chk_rd,
        output ld_issue_ready, ld_resp_ready, hazard,
        output wb_en, wb_reg, wb_val, alu_reg_w_en, alu_rd, alu_out, outstanding
`ifdef RF_WB_FWD_EN
        , output fwd1_en, fwd1_val, fwd2_en, fwd2_val
`endif
    );

endinterface

// File: rtl/wb_tag_fifo.sv
// In-order FIFO of pending load destination registers; exposes its live entries
// (valid mask + raw slots) so the hazard search never sees stale slots.
module wb_tag_fifo
    import rv32_wb_pkg::*;
#(
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  reg_idx_t                push_rd_i,
    input  logic                    pop_i,
    output reg_idx_t                head_rd_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [PTR_W:0]          count_o,
    output logic [DEPTH-1:0]        valid_o,
    output reg_idx_t [DEPTH-1:0]    entries_o
);

    reg_idx_t [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]     wptr_q, wptr_d;
    logic [PTR_W-1:0]     rptr_q, rptr_d;
    logic [PTR_W:0]       count_q, count_d;
    logic                 push, pop;
    logic [PTR_W-1:0]     off;

    assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign head_rd_o = mem_q[rptr_q];
    assign entries_o = mem_q;

    always_comb begin
        push    = push_i && !full_o;
        pop     = pop_i && !empty_o;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            mem_d[wptr_q] = push_rd_i;
            wptr_d        = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Slot i is live when its distance from the head is below the count.
    always_comb begin
        valid_o = '0;
        off     = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            off        = PTR_W'(i) - rptr_q;
            valid_o[i] = ({1'b0, off} < count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Writer-side controller for the RV32 register file: registered load and ALU write
// ports, in-order load tag tracking and operand hazard detection.
// Optional forwarding outputs are built when RF_WB_FWD_EN is defined.
module rf_writeback_ctrl
    import rv32_wb_pkg::*;
#(
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    rf_writeback_ctrl_if.slave bus
);

    reg_idx_t             head_rd;
    logic                 full, empty;
    logic [PTR_W:0]       count;
    logic [DEPTH-1:0]     valid;
    reg_idx_t [DEPTH-1:0] entries;
    logic                 resp_fire;

    logic     wb_en_q, wb_en_d;
    reg_idx_t wb_reg_q, wb_reg_d;
    xlen_t    wb_val_q, wb_val_d;
    logic     alu_reg_w_en_q, alu_reg_w_en_d;
    reg_idx_t alu_rd_q, alu_rd_d;
    xlen_t    alu_out_q, alu_out_d;

    logic fifo_hit_rs1, fifo_hit_rs2, fifo_hit_rd;
    logic stage_hit_rs1, stage_hit_rs2, stage_hit_rd;

    wb_tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (bus.ld_issue_valid),
        .push_rd_i (bus.ld_issue_rd),
        .pop_i     (bus.ld_resp_valid),
        .head_rd_o (head_rd),
        .full_o    (full),
        .empty_o   (empty),
        .count_o   (count),
        .valid_o   (valid),
        .entries_o (entries)
    );

    assign resp_fire = bus.ld_resp_valid && !empty;

    always_comb begin
        wb_en_d        = resp_fire && (head_rd != REG_ZERO);
        wb_reg_d       = resp_fire ? head_rd : wb_reg_q;
        wb_val_d       = resp_fire ? bus.ld_resp_data : wb_val_q;
        alu_reg_w_en_d = bus.alu_valid && (bus.alu_rd_in != REG_ZERO);
        alu_rd_d       = bus.alu_rd_in;
        alu_out_d      = bus.alu_result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_q        <= 1'b0;
            wb_reg_q       <= '0;
            wb_val_q       <= '0;
            alu_reg_w_en_q <= 1'b0;
            alu_rd_q       <= '0;
            alu_out_q      <= '0;
        end else begin
            wb_en_q        <= wb_en_d;
            wb_reg_q       <= wb_reg_d;
            wb_val_q       <= wb_val_d;
            alu_reg_w_en_q <= alu_reg_w_en_d;
            alu_rd_q       <= alu_rd_d;
            alu_out_q      <= alu_out_d;
        end
    end

    always_comb begin
        fifo_hit_rs1 = 1'b0;
        fifo_hit_rs2 = 1'b0;
        fifo_hit_rd  = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            fifo_hit_rs1 |= valid[i] && idx_match(bus.chk_rs1, entries[i]);
            fifo_hit_rs2 |= valid[i] && idx_match(bus.chk_rs2, entries[i]);
            fifo_hit_rd  |= valid[i] && idx_match(bus.chk_rd, entries[i]);
        end
        stage_hit_rs1 = (wb_en_q && idx_match(bus.chk_rs1, wb_reg_q)) ||
                        (alu_reg_w_en_q && idx_match(bus.chk_rs1, alu_rd_q));
        stage_hit_rs2 = (wb_en_q && idx_match(bus.chk_rs2, wb_reg_q)) ||
                        (alu_reg_w_en_q && idx_match(bus.chk_rs2, alu_rd_q));
        stage_hit_rd  = (wb_en_q && idx_match(bus.chk_rd, wb_reg_q)) ||
                        (alu_reg_w_en_q && idx_match(bus.chk_rd, alu_rd_q));
    end

`ifdef RF_WB_FWD_EN
    // Sources read from the output stage are forwarded, so only the rd WAW check stalls on it.
    assign bus.hazard   = fifo_hit_rs1 | fifo_hit_rs2 | fifo_hit_rd | stage_hit_rd;
    assign bus.fwd1_en  = stage_hit_rs1;
    assign bus.fwd2_en  = stage_hit_rs2;
    // The ALU op is younger, so its value wins when both ports match.
    assign bus.fwd1_val = (alu_reg_w_en_q && idx_match(bus.chk_rs1, alu_rd_q)) ? alu_out_q
                                                                                : wb_val_q;
    assign bus.fwd2_val = (alu_reg_w_en_q && idx_match(bus.chk_rs2, alu_rd_q)) ? alu_out_q
                                                                                : wb_val_q;
`else
    assign bus.hazard   = fifo_hit_rs1 | fifo_hit_rs2 | fifo_hit_rd |
                          stage_hit_rs1 | stage_hit_rs2 | stage_hit_rd;
`endif

    assign bus.ld_issue_ready = !full;
    assign bus.ld_resp_ready  = !empty;
    assign bus.outstanding    = count;
    assign bus.wb_en          = wb_en_q;
    assign bus.wb_reg         = wb_reg_q;
    assign bus.wb_val         = wb_val_q;
    assign bus.alu_reg_w_en   = alu_reg_w_en_q;
    assign bus.alu_rd         = alu_rd_q;
    assign bus.alu_out        = alu_out_q;

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed self-checking bench for rf_writeback_ctrl (DEPTH=4); covers RF_WB_FWD_EN when defined.
module tb_rf_writeback_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [31:0] rf_model [32];

    rf_writeback_ctrl_if #(.DEPTH(4)) bus ();

    rf_writeback_ctrl #(
        .DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: ALU port written last so it takes priority.
    always @(posedge clk) begin
        if (bus.wb_en) rf_model[bus.wb_reg] <= bus.wb_val;
        if (bus.alu_reg_w_en) rf_model[bus.alu_rd] <= bus.alu_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 32; i++) rf_model[i] = '0;
        rst                = 1'b1;
        bus.alu_valid      = 1'b0;
        bus.alu_rd_in      = '0;
        bus.alu_result     = '0;
        bus.ld_issue_valid = 1'b0;
        bus.ld_issue_rd    = '0;
        bus.ld_resp_valid  = 1'b0;
        bus.ld_resp_data   = '0;
        bus.chk_rs1        = '0;
        bus.chk_rs2        = '0;
        bus.chk_rd         = '0;

        // Reset then idle
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_wb_en", 32'(bus.wb_en), 32'd0);
        chk("rst_wb_val", bus.wb_val, 32'd0);
        chk("rst_alu_w_en", 32'(bus.alu_reg_w_en), 32'd0);
        chk("rst_alu_out", bus.alu_out, 32'd0);
        chk("rst_outstanding", 32'(bus.outstanding), 32'd0);
        chk("rst_issue_ready", 32'(bus.ld_issue_ready), 32'd1);
        chk("rst_resp_ready", 32'(bus.ld_resp_ready), 32'd0);
        chk("rst_hazard", 32'(bus.hazard), 32'd0);

        // Two loads x5, x6 and in-order responses
        bus.ld_issue_valid = 1'b1;
        bus.ld_issue_rd    = 5'd5;
        tick();
        bus.ld_issue_rd    = 5'd6;
        tick();
        bus.ld_issue_valid = 1'b0;
        bus.chk_rs1        = 5'd5;
        #1;
        chk("two_outstanding", 32'(bus.outstanding), 32'd2);
        chk("haz_x5_pending", 32'(bus.hazard), 32'd1);
        bus.ld_resp_valid = 1'b1;
        bus.ld_resp_data  = 32'hAAAA_0001;
        tick();
        chk("wb1_en", 32'(bus.wb_en), 32'd1);
        chk("wb1_reg", 32'(bus.wb_reg), 32'd5);
        chk("wb1_val", bus.wb_val, 32'hAAAA_0001);
`ifdef RF_WB_FWD_EN
        chk("haz_x5_pulse_fwd", 32'(bus.hazard), 32'd0);
        chk("fwd1_en_x5", 32'(bus.fwd1_en), 32'd1);
        chk("fwd1_val_x5", bus.fwd1_val, 32'hAAAA_0001);
`else
        chk("haz_x5_pulse", 32'(bus.hazard), 32'd1);
`endif
        bus.ld_resp_data = 32'hBBBB_0002;
        tick();
        chk("wb2_en", 32'(bus.wb_en), 32'd1);
        chk("wb2_reg", 32'(bus.wb_reg), 32'd6);
        chk("wb2_val", bus.wb_val, 32'hBBBB_0002);
        chk("haz_x5_cleared", 32'(bus.hazard), 32'd0);
        chk("drained_outstanding", 32'(bus.outstanding), 32'd0);
        bus.ld_resp_valid = 1'b0;
        tick();
        chk("wb_pulse_single", 32'(bus.wb_en), 32'd0);
        chk("empty_resp_ready", 32'(bus.ld_resp_ready), 32'd0);

        // Fill to DEPTH, then simultaneous issue+response when full
        bus.chk_rs1        = 5'd0;
        bus.ld_issue_valid = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            bus.ld_issue_rd = 5'(r);
            tick();
        end
        chk("full_outstanding", 32'(bus.outstanding), 32'd4);
        chk("full_issue_ready", 32'(bus.ld_issue_ready), 32'd0);
        bus.ld_resp_valid = 1'b1;
        bus.ld_resp_data  = 32'h10;
        bus.chk_rd        = 5'd4;
        #1;
        chk("haz_waw_rd4", 32'(bus.hazard), 32'd1);
        tick();
        chk("full_pushpop_count", 32'(bus.outstanding), 32'd3);
        chk("full_pop_wb_reg", 32'(bus.wb_reg), 32'd1);
        chk("full_pop_wb_val", bus.wb_val, 32'h10);
        bus.ld_issue_valid = 1'b0;
        bus.ld_resp_valid  = 1'b0;
        bus.chk_rd         = 5'd0;
        bus.chk_rs2        = 5'd1;
        tick();
        chk("haz_stale_slot", 32'(bus.hazard), 32'd0);
        bus.chk_rs2 = 5'd3;
        #1;
        chk("haz_live_x3", 32'(bus.hazard), 32'd1);
        bus.chk_rs2       = 5'd0;
        bus.ld_resp_valid = 1'b1;
        bus.ld_resp_data  = 32'h20;
        tick();
        tick();
        tick();
        bus.ld_resp_valid = 1'b0;
        chk("drain_outstanding", 32'(bus.outstanding), 32'd0);
        chk("drain_last_reg", 32'(bus.wb_reg), 32'd4);
        chk("drain_last_en", 32'(bus.wb_en), 32'd1);

        // Load to x0
        bus.ld_issue_valid = 1'b1;
        bus.ld_issue_rd    = 5'd0;
        tick();
        bus.ld_issue_valid = 1'b0;
        #1;
        chk("x0_pending_count", 32'(bus.outstanding), 32'd1);
        chk("x0_no_hazard", 32'(bus.hazard), 32'd0);
        bus.ld_resp_valid = 1'b1;
        bus.ld_resp_data  = 32'h1234;
        tick();
        bus.ld_resp_valid = 1'b0;
        chk("x0_wb_en", 32'(bus.wb_en), 32'd0);
        chk("x0_outstanding", 32'(bus.outstanding), 32'd0);

        // ALU and load both write x7 in the same cycle
        bus.ld_issue_valid = 1'b1;
        bus.ld_issue_rd    = 5'd7;
        tick();
        bus.ld_issue_valid = 1'b0;
        bus.alu_valid      = 1'b1;
        bus.alu_rd_in      = 5'd7;
        bus.alu_result     = 32'h55;
        bus.ld_resp_valid  = 1'b1;
        bus.ld_resp_data   = 32'h99;
        tick();
        bus.alu_valid     = 1'b0;
        bus.ld_resp_valid = 1'b0;
        chk("dual_alu_en", 32'(bus.alu_reg_w_en), 32'd1);
        chk("dual_alu_rd", 32'(bus.alu_rd), 32'd7);
        chk("dual_alu_out", bus.alu_out, 32'h55);
        chk("dual_wb_en", 32'(bus.wb_en), 32'd1);
        chk("dual_wb_reg", 32'(bus.wb_reg), 32'd7);
        chk("dual_wb_val", bus.wb_val, 32'h99);
        tick();
        chk("rf_x7_alu_wins", rf_model[7], 32'h55);
        chk("alu_pulse_single", 32'(bus.alu_reg_w_en), 32'd0);

        // Reset with three outstanding loads
        bus.ld_issue_valid = 1'b1;
        for (int r = 10; r <= 12; r++) begin
            bus.ld_issue_rd = 5'(r);
            tick();
        end
        bus.ld_issue_valid = 1'b0;
        chk("pre_rst_outstanding", 32'(bus.outstanding), 32'd3);
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        bus.chk_rs1 = 5'd10;
        #1;
        chk("flush_outstanding", 32'(bus.outstanding), 32'd0);
        chk("flush_hazard", 32'(bus.hazard), 32'd0);
        chk("flush_resp_ready", 32'(bus.ld_resp_ready), 32'd0);
        bus.ld_resp_valid = 1'b1;
        bus.ld_resp_data  = 32'hDEAD;
        tick();
        bus.ld_resp_valid = 1'b0;
        chk("flush_resp_refused", 32'(bus.wb_en), 32'd0);
        chk("flush_count_stays", 32'(bus.outstanding), 32'd0);

        // ALU result to x9 queried as rs2
        bus.chk_rs1    = 5'd0;
        bus.alu_valid  = 1'b1;
        bus.alu_rd_in  = 5'd9;
        bus.alu_result = 32'h77;
        bus.chk_rs2    = 5'd9;
        tick();
        bus.alu_valid = 1'b0;
`ifdef RF_WB_FWD_EN
        chk("fwd2_en_x9", 32'(bus.fwd2_en), 32'd1);
        chk("fwd2_val_x9", bus.fwd2_val, 32'h77);
        chk("fwd1_en_idle", 32'(bus.fwd1_en), 32'd0);
        chk("haz_x9_fwd", 32'(bus.hazard), 32'd0);
`else
        chk("haz_x9_alu", 32'(bus.hazard), 32'd1);
`endif
        bus.chk_rs2   = 5'd0;
        bus.chk_rd    = 5'd9;
        #1;
        chk("haz_rd_x9_alu", 32'(bus.hazard), 32'd1);
        bus.chk_rd    = 5'd0;
        bus.alu_valid = 1'b1;
        bus.alu_rd_in = 5'd0;
        tick();
        bus.alu_valid = 1'b0;
        chk("alu_x0_no_write", 32'(bus.alu_reg_w_en), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_writeback_ctrl.md
Name: rf_writeback_ctrl

Overview:
- Writer-side controller for the RV32 32x32 register file.
- Drives both register-file write ports:
  - load port: wb_en / wb_reg / wb_val
  - ALU port: alu_reg_w_en / alu_rd / alu_out
- Tracks outstanding in-order loads in a tag FIFO and answers operand-hazard queries so issue stalls until pending writes land.
- Sits between execute/memory stages and the register file.

Parameters:
- DEPTH, 4, max outstanding loads; power of 2, range 2..16.
- PTR_W, $clog2(DEPTH), FIFO pointer width; derived, not overridable.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- alu_valid  in  1  ALU result valid this cycle; no backpressure.
- alu_rd_in  in  5  ALU destination register.
- alu_result  in  32  ALU result.
- ld_issue_valid  in  1  load issued.
- ld_issue_rd  in  5  load destination register.
- ld_issue_ready  out  1  load issue accepted; equals !full.
- ld_resp_valid  in  1  memory response valid; responses arrive in issue order.
- ld_resp_data  in  32  load data.
- ld_resp_ready  out  1  response accepted; equals !empty.
- chk_rs1, chk_rs2, chk_rd  in  5 each  issue-stage operand/destination query.
- hazard  out  1  combinational stall request.
- wb_en, wb_reg, wb_val  out  1/5/32  registered load write port.
- alu_reg_w_en, alu_rd, alu_out  out  1/5/32  registered ALU write port.
- outstanding  out  PTR_W+1  count of FIFO entries.

Behaviour:
- Reset values:
  - all outputs 0; FIFO empty; outstanding=0.
  - ld_resp_ready=0; ld_issue_ready=1 from the first cycle after reset.
- Reset mid-operation flushes all pending tags; later responses for flushed loads are refused (ready=0).
- Issue handshake:
  - push ld_issue_rd when ld_issue_valid && ld_issue_ready.
  - ld_issue_ready=0 when full; there is no same-cycle pop bypass.
- Response handshake:
  - pop the head when ld_resp_valid && ld_resp_ready.
  - next cycle: wb_reg=head rd, wb_val=ld_resp_data, wb_en=1 if rd!=0, else wb_en=0 and the data is discarded.
  - wb_en is a single-cycle pulse per response.
  - response accept latency is 1 cycle.
- Simultaneous push and pop:
  - allowed whenever not full and not empty; count is unchanged.
  - in the empty state no pop occurs; the push lands normally.
- Pointers wrap modulo DEPTH; full/empty distinguished by the count.
- ALU path:
  - alu_valid registered straight through; 1-cycle latency.
  - alu_reg_w_en=alu_valid && alu_rd_in!=0; alu_rd/alu_out follow.
- Same-cycle ALU and load write to the same rd: both ports are asserted. The register file gives the ALU port priority, which is correct because the ALU op is younger.
- Hazard (combinational):
  - asserted if any nonzero chk_* equals any valid FIFO entry rd.
  - also asserted if it equals the registered wb_reg while wb_en=1, or alu_rd while alu_reg_w_en=1.
  - x0 never hazards.
  - chk_rd is included to block WAW against an older pending load.
- Search covers only valid entries (head..tail), never stale slots.
- The block has no state machine beyond the FIFO and the output registers. outstanding mirrors the count.

Optional Feature:
- Macro: RF_WB_FWD_EN.
- Defined:
  - adds outputs fwd1_en, fwd1_val[31:0], fwd2_en, fwd2_val[31:0].
  - fwdN_en=1 when chk_rsN!=0 matches the registered output stage. ALU port wins if both match.
  - the output-stage term is removed from hazard for chk_rs1/chk_rs2 only; chk_rd keeps it.
- Undefined: ports absent; hazard includes the output-stage term as above.

Decomposition:
- Package rv32_wb_pkg:
  - XLEN=32, REG_AW=5, REG_ZERO=5'd0.
  - typedef reg_idx_t [4:0], xlen_t [31:0].
- Sub-module wb_tag_fifo:
  - DEPTH-entry rd FIFO with push/pop/count.
  - exports a valid-entry bitmask plus the entry array for the hazard search.

Test Plan:
- Reset then idle -> all outputs 0, ld_issue_ready=1, ld_resp_ready=0, outstanding=0.
- Issue loads to x5, x6; respond 0xAAAA_0001 then 0xBBBB_0002:
  - wb pulses x5=0xAAAA_0001, then x6=0xBBBB_0002, each 1 cycle after accept.
  - hazard for chk_rs1=5 holds until the x5 pulse cycle ends.
- Issue DEPTH=4 loads without responses -> ld_issue_ready=0, outstanding=4. Same cycle issue+response -> push refused, pop done, count=3.
- Load to x0 then response 0x1234 -> wb_en stays 0; chk_rs1=0 never raises hazard.
- alu_valid rd=7 val=0x55 in the same cycle as a load response for rd=7 val=0x99 -> both ports assert x7 next cycle; the register file ends at 0x55.
- rst asserted with 3 outstanding -> next cycle outstanding=0, hazard=0, response refused. With RF_WB_FWD_EN, ALU rd=9 val=0x77 and chk_rs2=9 -> fwd2_en=1, fwd2_val=0x77, hazard=0.
